// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - Thumb ALU-instruction issue stage: decode, register file, writeback, flags
module alu_issue #(
    parameter int                DATA_W    = 32,
    parameter int                NREGS     = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [15:0]       i_instr,
    input  logic              i_instr_valid,
    output logic              o_instr_ready,
    output logic [2:0]        o_alu_sel,
    output logic [DATA_W-1:0] o_alu_imm,
    output logic [DATA_W-1:0] o_alu_rn,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [3:0]        i_alu_apsr,
    output logic [3:0]        o_apsr,
    output logic              o_done,
    output logic              o_illegal,
    input  logic [2:0]        i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data
);
    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

    typedef struct packed {
        logic       legal;
        logic [2:0] sel;
        logic [2:0] rd;
        logic [2:0] rs;
        logic       wr;
        logic       fl;
    } dec_t;

    // rs is the register feeding o_alu_rn: Rd for the imm8 forms, Rm for MOV.
    function automatic dec_t decode(input logic [15:0] ins);
        dec_t d;
        d    = '0;
        d.rd = ins[10:8];
        d.rs = ins[10:8];
        case (ins[15:11])
            5'b00100: begin d.legal = 1'b1; d.sel = 3'b001; d.wr = 1'b1; d.fl = 1'b1; end
            5'b00101: begin d.legal = 1'b1; d.sel = 3'b101; d.wr = 1'b0; d.fl = 1'b1; end
            5'b00110: begin d.legal = 1'b1; d.sel = 3'b000; d.wr = 1'b1; d.fl = 1'b1; end
            5'b00111: begin d.legal = 1'b1; d.sel = 3'b101; d.wr = 1'b1; d.fl = 1'b1; end
            default: begin
                if (ins[15:8] == 8'h46 && ins[7:6] == 2'b00) begin
                    d.legal = 1'b1;
                    d.sel   = 3'b010;
                    d.rd    = ins[2:0];
                    d.rs    = ins[5:3];
                    d.wr    = 1'b1;
                    d.fl    = 1'b0;
                end
            end
        endcase
        return d;
    endfunction

    state_t            state_q, state_d;
    logic [15:0]       instr_q, instr_d;
    logic [2:0]        sel_q, sel_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] rn_q, rn_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [3:0]        flags_q, flags_d;
    logic [3:0]        apsr_q, apsr_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              illegal_q, illegal_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    dec_t              dec_in, dec_cur;

    always_comb begin
        dec_in    = decode(i_instr);
        dec_cur   = decode(instr_q);
        state_d   = state_q;
        instr_d   = instr_q;
        sel_d     = sel_q;
        imm_d     = imm_q;
        rn_d      = rn_q;
        res_d     = res_q;
        flags_d   = flags_q;
        apsr_d    = apsr_q;
        regs_d    = regs_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_instr_valid) begin
                    instr_d   = i_instr;
                    state_d   = S_DECODE;
                    // Flagged at capture so the pulse lines up with the DECODE cycle.
                    illegal_d = !dec_in.legal;
                end
            end
            S_DECODE: begin
                if (dec_cur.legal) begin
                    sel_d   = dec_cur.sel;
                    imm_d   = DATA_W'(instr_q[7:0]);
                    rn_d    = regs_q[dec_cur.rs];
                    state_d = S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                res_d   = i_alu_result;
                flags_d = i_alu_apsr;
                done_d  = 1'b1;
                state_d = S_WB;
            end
            S_WB: begin
                if (dec_cur.wr) regs_d[dec_cur.rd] = res_q;
                if (dec_cur.fl) apsr_d = flags_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            sel_q     <= '0;
            imm_q     <= '0;
            rn_q      <= '0;
            res_q     <= '0;
            flags_q   <= '0;
            apsr_q    <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= RESET_VAL;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            sel_q     <= sel_d;
            imm_q     <= imm_d;
            rn_q      <= rn_d;
            res_q     <= res_d;
            flags_q   <= flags_d;
            apsr_q    <= apsr_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            regs_q    <= regs_d;
        end
    end

    assign o_instr_ready = ready_q;
    assign o_alu_sel     = sel_q;
    assign o_alu_imm     = imm_q;
    assign o_alu_rn      = rn_q;
    assign o_apsr        = apsr_q;
    assign o_done        = done_q;
    assign o_illegal     = illegal_q;
    assign o_dbg_data    = regs_q[i_dbg_addr];
endmodule
